// File: rtl/dac_stream_feeder.sv
// Sample buffer feeding the DAC one sample per clk: FIFO with prefill-gated playback,
// underflow detection with a selectable fill policy, and a saturating starvation counter.
module dac_stream_feeder #(
  parameter int bits      = 16,
  parameter int depth     = 16,
  parameter int prefill   = 4,
  parameter int hold_last = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [bits-1:0]          s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [bits-1:0]          dac_data,
  output logic                     running,
  output logic                     underflow,
  output logic [15:0]              underflow_cnt,
  output logic [$clog2(depth):0]   fill
);

  localparam int aw = $clog2(depth);
  localparam logic [aw:0] full_c    = (aw+1)'(depth);
  localparam logic [aw:0] prefill_c = (aw+1)'(prefill);
  localparam logic [aw:0] empty_c   = (aw+1)'(0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t            state_r;
  logic [bits-1:0]   mem_r [depth];
  logic [aw-1:0]     wr_ptr_r;
  logic [aw-1:0]     rd_ptr_r;
  logic [aw:0]       fill_r;
  logic [bits-1:0]   dac_data_r;
  logic              running_r;
  logic              underflow_r;
  logic [15:0]       underflow_cnt_r;
  logic              wr_s;
  logic              rd_s;

  // No pass-through: a full buffer refuses data even when a pop happens this cycle.
  assign s_axis_tready = !rst && (fill_r != full_c);
  assign wr_s          = s_axis_tvalid && s_axis_tready;

  // Pop decision: only while playing, enabled, and with data already stored.
  always_comb begin
    rd_s = 1'b0;
    if ((state_r == RUN) && en && (fill_r != empty_c)) begin
      rd_s = 1'b1;
    end else begin
      rd_s = 1'b0;
    end
  end

  // Sample storage; tready is low during reset so no write can occur then.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= s_axis_tdata;
    end
  end

  // Wrapping pointers and occupancy counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= aw'(0);
      rd_ptr_r <= aw'(0);
      fill_r   <= empty_c;
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + aw'(1);
      end
      if (rd_s) begin
        rd_ptr_r <= rd_ptr_r + aw'(1);
      end
      case ({wr_s, rd_s})
        2'b10:   fill_r <= fill_r + (aw+1)'(1);
        2'b01:   fill_r <= fill_r - (aw+1)'(1);
        default: fill_r <= fill_r;
      endcase
    end
  end

  // Playback state machine with registered DAC sample and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      dac_data_r      <= {bits{1'b0}};
      running_r       <= 1'b0;
      underflow_r     <= 1'b0;
      underflow_cnt_r <= 16'h0000;
    end else if (!en) begin
      state_r     <= IDLE;
      dac_data_r  <= {bits{1'b0}};
      running_r   <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r     <= PREFILL;
          running_r   <= 1'b0;
          underflow_r <= 1'b0;
        end
        PREFILL: begin
          underflow_r <= 1'b0;
          if (fill_r >= prefill_c) begin
            state_r   <= RUN;
            running_r <= 1'b1;
          end else begin
            running_r <= 1'b0;
          end
        end
        RUN: begin
          if (fill_r != empty_c) begin
            dac_data_r  <= mem_r[rd_ptr_r];
            underflow_r <= 1'b0;
            running_r   <= 1'b1;
          end else begin
            // Starved: apply the fill policy and go back to gathering a prefill.
            dac_data_r  <= (hold_last != 0) ? dac_data_r : {bits{1'b0}};
            underflow_r <= 1'b1;
            running_r   <= 1'b0;
            state_r     <= PREFILL;
            if (underflow_cnt_r != 16'hFFFF) begin
              underflow_cnt_r <= underflow_cnt_r + 16'd1;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          dac_data_r  <= {bits{1'b0}};
          running_r   <= 1'b0;
          underflow_r <= 1'b0;
        end
      endcase
    end
  end

  assign dac_data      = dac_data_r;
  assign running       = running_r;
  assign underflow     = underflow_r;
  assign underflow_cnt = underflow_cnt_r;
  assign fill          = fill_r;

endmodule

// File: tb/tb_dac_stream_feeder.sv
// Scoreboard bench: two feeders (zero-fill and hold-last) share stimulus; a queue-based
// reference model predicts every cycle and a negedge monitor compares.
module tb_dac_stream_feeder;

  localparam int DEPTH   = 16;
  localparam int PREFILL = 4;
  localparam int M_IDLE = 0, M_PREFILL = 1, M_RUN = 2;

  logic        clk = 1'b0;
  logic        rst, en, tvalid;
  logic [15:0] tdata;
  logic        tready0, tready1, run0, run1, uf0, uf1;
  logic [15:0] dac0, dac1, cnt0, cnt1;
  logic [4:0]  fill0, fill1;

  always #5 clk = ~clk;

  dac_stream_feeder #(.bits(16), .depth(DEPTH), .prefill(PREFILL), .hold_last(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready0), .dac_data(dac0), .running(run0), .underflow(uf0),
    .underflow_cnt(cnt0), .fill(fill0));

  dac_stream_feeder #(.bits(16), .depth(DEPTH), .prefill(PREFILL), .hold_last(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready1), .dac_data(dac1), .running(run1), .underflow(uf1),
    .underflow_cnt(cnt1), .fill(fill1));

  typedef struct {
    logic [15:0] dac;
    logic        running;
    logic        uf;
    logic [15:0] cnt;
    int          fill;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  // Behavioural model: a sample list per instance plus a playback mode.
  logic [15:0] mfifo [2][DEPTH];
  int          mhead [2];
  int          mcnt  [2];
  int          mode  [2];
  logic [15:0] mdac  [2];
  logic [15:0] mucnt [2];

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp_v);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mhead[k] = 0; mcnt[k] = 0; mode[k] = M_IDLE; mdac[k] = 16'h0; mucnt[k] = 16'h0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        exp_t e;
        bit   wr;
        bit   rd;
        bit   uf;
        int   widx;
        rd = 1'b0;
        uf = 1'b0;
        if (rst) begin
          mhead[k] = 0; mcnt[k] = 0; mode[k] = M_IDLE; mdac[k] = 16'h0; mucnt[k] = 16'h0;
        end else begin
          wr   = tvalid && (mcnt[k] != DEPTH);
          widx = (mhead[k] + mcnt[k]) % DEPTH;
          if (!en) begin
            mode[k] = M_IDLE;
            mdac[k] = 16'h0;
          end else if (mode[k] == M_IDLE) begin
            mode[k] = M_PREFILL;
          end else if (mode[k] == M_PREFILL) begin
            if (mcnt[k] >= PREFILL) mode[k] = M_RUN;
          end else if (mcnt[k] > 0) begin
            rd = 1'b1;
            mdac[k] = mfifo[k][mhead[k]];
          end else begin
            uf = 1'b1;
            if (k == 0) mdac[k] = 16'h0;
            if (mucnt[k] != 16'hFFFF) mucnt[k] = mucnt[k] + 16'd1;
            mode[k] = M_PREFILL;
          end
          if (wr) mfifo[k][widx] = tdata;
          if (rd) mhead[k] = (mhead[k] + 1) % DEPTH;
          mcnt[k] = mcnt[k] + (wr ? 1 : 0) - (rd ? 1 : 0);
        end
        e.dac = mdac[k]; e.running = (mode[k] == M_RUN); e.uf = uf;
        e.cnt = mucnt[k]; e.fill = mcnt[k];
        if (k == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
      end
    end
  end

  // Monitor: pops predictions and compares away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q0.size() > 0) begin
        exp_t e;
        e = exp_q0.pop_front();
        chk("dac0",   32'(dac0),    32'(e.dac));
        chk("run0",   32'(run0),    32'(e.running));
        chk("uf0",    32'(uf0),     32'(e.uf));
        chk("cnt0",   32'(cnt0),    32'(e.cnt));
        chk("fill0",  32'(fill0),   32'(e.fill));
        chk("tready0", 32'(tready0), 32'(!rst && (mcnt[0] != DEPTH)));
      end
      if (exp_q1.size() > 0) begin
        exp_t e;
        e = exp_q1.pop_front();
        chk("dac1",   32'(dac1),    32'(e.dac));
        chk("run1",   32'(run1),    32'(e.running));
        chk("uf1",    32'(uf1),     32'(e.uf));
        chk("cnt1",   32'(cnt1),    32'(e.cnt));
        chk("fill1",  32'(fill1),   32'(e.fill));
        chk("tready1", 32'(tready1), 32'(!rst && (mcnt[1] != DEPTH)));
      end
    end
  end

  task automatic step(input logic e, input logic v, input logic [15:0] d);
    en = e; tvalid = v; tdata = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; tvalid = 1'b0; tdata = 16'h0;
    repeat (3) step(1'b0, 1'b0, 16'h0);
    rst = 1'b0;
    step(1'b0, 1'b0, 16'h0);

    // Prefill with 1..4 then play them out and starve.
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 16'(i));
    repeat (8) step(1'b1, 1'b0, 16'($urandom));

    // Overfill while idle, then play 16 samples straight through a pointer wrap.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 16'(i));
    repeat (20) step(1'b1, 1'b0, 16'h0);

    // Four samples ending with 0x1234, starve, then refill ending in 0x8000.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'($urandom));
    step(1'b1, 1'b1, 16'h1234);
    repeat (8) step(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'($urandom));
    step(1'b1, 1'b1, 16'h8000);
    repeat (8) step(1'b1, 1'b0, 16'h0);

    // Steady stream, pause mid-stream, then resume from the retained samples.
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 16'($urandom));
    repeat (3) step(1'b0, 1'b0, 16'h0);
    repeat (10) step(1'b1, 1'b0, 16'h0);

    // Reach fill=9 while running, then reset mid-run.
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 16'($urandom));
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 16'($urandom));
    rst = 1'b1;
    step(1'b1, 1'b0, 16'h0);
    rst = 1'b0;
    step(1'b0, 1'b0, 16'h0);

    // Saturation: preset the counter to 0xFFFF and starve once more.
    @(negedge clk);
    #1;
    force dut0.underflow_cnt_r = 16'hFFFF;
    force dut1.underflow_cnt_r = 16'hFFFF;
    #1;
    release dut0.underflow_cnt_r;
    release dut1.underflow_cnt_r;
    mucnt[0] = 16'hFFFF;
    mucnt[1] = 16'hFFFF;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 16'($urandom));
    repeat (8) step(1'b1, 1'b0, 16'h0);

    // Randomized traffic with occasional enable drops and resets.
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 15) != 0, $urandom_range(0, 99) < 55, 16'($urandom));
    end
    rst = 1'b0;
    repeat (4) step(1'b0, 1'b0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
